fetch_unit: RTL and testbench

- Consumer side of the program counter interface.
- Takes the current fetch address `pc_in` from the PC register and issues one instruction-memory read per address over a valid/ready request channel.
- Buffers returned instructions, tagged with their PC, in a small queue feeding decode.
- Drives `stall_out` back to the PC whenever the current address has not been consumed. Discards in-flight and buffered fetches on `flush` (jump).

---
 rtl/fetch_unit.sv | 79 +++++++
 tb/tb_fetch_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: issues one instruction read per PC and queues tagged responses for decode
module fetch_unit #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_in,
  output logic            stall_out,
  input  logic            flush,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output logic            dec_valid,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  input  logic            dec_ready
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [XLEN-1:0] opc_q, opc_d;
  logic [XLEN-1:0] instr_q [DEPTH];
  logic [XLEN-1:0] instr_d [DEPTH];
  logic [XLEN-1:0] pcs_q [DEPTH];
  logic [XLEN-1:0] pcs_d [DEPTH];
  logic fire, push, pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  always_comb begin
    mem_req_addr = pc_in;
    mem_req_valid = state_q == REQ && !flush && count_q < CW'(DEPTH);
    fire = mem_req_valid && mem_req_ready;
    stall_out = !fire;
    dec_valid = count_q != '0;
    dec_instr = instr_q[rp_q];
    dec_pc = pcs_q[rp_q];
    push = state_q == WAIT && mem_resp_valid && !flush;
    pop = dec_valid && dec_ready && !flush;
    state_d = state_q == IDLE ? REQ :
              state_q == REQ  ? (fire ? WAIT : REQ) :
              mem_resp_valid  ? REQ :
              flush           ? DRAIN : state_q;
    opc_d = fire ? pc_in : opc_q;
    instr_d = instr_q;
    pcs_d = pcs_q;
    if (push) begin
      instr_d[wp_q] = mem_resp_data;
      pcs_d[wp_q] = opc_q;
    end
    wp_d = flush ? '0 : push ? nxt(wp_q) : wp_q;
    rp_d = flush ? '0 : pop ? nxt(rp_q) : rp_q;
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end
  always_ff @(posedge clk) begin
    opc_q <= opc_d;
    instr_q <= instr_d;
    pcs_q <= pcs_d;
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a scoreboard queue checked by a decode-side monitor
module tb_fetch_unit;
  localparam int XLEN = 32;
  localparam int DEPTH = 2;
  logic clk = 0, rst_n = 0, flush = 0;
  logic [XLEN-1:0] pc_in = '0, mem_req_addr, mem_resp_data = '0, dec_instr, dec_pc;
  logic stall_out, mem_req_valid, mem_req_ready = 0, mem_resp_valid = 0;
  logic dec_valid, dec_ready = 0;
  typedef struct packed {logic [XLEN-1:0] pc; logic [XLEN-1:0] instr;} ent_t;
  ent_t exp_q[$];
  int tests = 0, fails = 0;
  fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .stall_out(stall_out), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_ready(dec_ready)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  always @(negedge clk) begin
    ent_t e;
    if (rst_n && dec_valid && dec_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL dec_unexpected: got pc %h instr %h expected no output", dec_pc, dec_instr);
      end else begin
        e = exp_q.pop_front();
        check("dec_pc", dec_pc, e.pc);
        check("dec_instr", dec_instr, e.instr);
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [XLEN-1:0] pc);
    bit done;
    done = 0;
    pc_in = pc;
    mem_req_ready = 1;
    #1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (mem_req_valid && mem_req_ready) begin
        done = 1;
        check("stall_on_fire", {31'b0, stall_out}, 0);
        check("req_addr", mem_req_addr, pc);
      end
      tick;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: got no request for %h expected one within 20 cycles", pc);
    end
    mem_req_ready = 0;
  endtask
  task automatic respond(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] instr, input int delay, input bit keep);
    repeat (delay) tick;
    mem_resp_valid = 1;
    mem_resp_data = instr;
    if (keep) exp_q.push_back({pc, instr});
    tick;
    mem_resp_valid = 0;
    mem_req_ready = 0;
  endtask
  task automatic fetch(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] instr);
    issue(pc);
    respond(pc, instr, 0, 1);
  endtask
  initial begin
    tick;
    tick;
    check("rst_req_valid", {31'b0, mem_req_valid}, 0);
    check("rst_stall", {31'b0, stall_out}, 1);
    check("rst_dec_valid", {31'b0, dec_valid}, 0);
    rst_n = 1;
    dec_ready = 1;
    #1;
    check("idle_req_valid", {31'b0, mem_req_valid}, 0);
    check("idle_dec_valid", {31'b0, dec_valid}, 0);
    tick;
    check("req1_dec_valid", {31'b0, dec_valid}, 0);
    fetch(32'h0, 32'h0000_0013);
    fetch(32'h4, 32'h0000_0013);
    fetch(32'h8, 32'h0000_0013);
    tick;
    check("t1_drained", exp_q.size(), 0);
    dec_ready = 0;
    fetch(32'h0, 32'h1111_1111);
    fetch(32'h4, 32'h2222_2222);
    pc_in = 32'h8;
    mem_req_ready = 1;
    #1;
    check("full_req_valid", {31'b0, mem_req_valid}, 0);
    check("full_stall", {31'b0, stall_out}, 1);
    tick;
    check("full_req_valid2", {31'b0, mem_req_valid}, 0);
    check("full_stall2", {31'b0, stall_out}, 1);
    mem_req_ready = 0;
    dec_ready = 1;
    tick;
    dec_ready = 0;
    #1;
    check("freed_req_valid", {31'b0, mem_req_valid}, 1);
    check("freed_req_addr", mem_req_addr, 32'h8);
    fetch(32'h8, 32'h3333_3333);
    dec_ready = 1;
    tick;
    dec_ready = 0;
    issue(32'h10);
    flush = 1;
    pc_in = 32'h100;
    #1;
    check("flush_stall", {31'b0, stall_out}, 1);
    check("flush_req_valid", {31'b0, mem_req_valid}, 0);
    check("flush_dec_valid_before", {31'b0, dec_valid}, 1);
    exp_q.delete();
    tick;
    flush = 0;
    #1;
    check("drain_dec_valid", {31'b0, dec_valid}, 0);
    check("drain_req_valid", {31'b0, mem_req_valid}, 0);
    respond(32'h10, 32'h1234_5678, 2, 0);
    check("drop_dec_valid", {31'b0, dec_valid}, 0);
    dec_ready = 1;
    fetch(32'h100, 32'h5555_5555);
    issue(32'h30);
    flush = 1;
    mem_resp_valid = 1;
    mem_resp_data = 32'hDEAD_BEEF;
    pc_in = 32'h200;
    tick;
    flush = 0;
    mem_resp_valid = 0;
    #1;
    check("t4_req_valid", {31'b0, mem_req_valid}, 1);
    check("t4_req_addr", mem_req_addr, 32'h200);
    check("t4_dec_valid", {31'b0, dec_valid}, 0);
    fetch(32'h200, 32'h6666_6666);
    pc_in = 32'h20;
    mem_req_ready = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t5_req_valid", {31'b0, mem_req_valid}, 1);
      check("t5_stall", {31'b0, stall_out}, 1);
      check("t5_req_addr", mem_req_addr, 32'h20);
      tick;
    end
    fetch(32'h20, 32'h7777_7777);
    issue(32'h40);
    rst_n = 0;
    exp_q.delete();
    tick;
    rst_n = 1;
    pc_in = 32'h80;
    mem_req_ready = 0;
    tick;
    tick;
    mem_resp_valid = 1;
    mem_resp_data = 32'hBAD0_BAD0;
    tick;
    mem_resp_valid = 0;
    #1;
    check("t6_dec_valid", {31'b0, dec_valid}, 0);
    fetch(32'h80, 32'h8888_8888);
    tick;
    check("final_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
